// File: rtl/flow_ctrl_pkg.sv
// Shared opcodes, status bit positions and state encoding for the program-flow unit.
package flow_ctrl_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned ST_W = 3;

  localparam logic [OP_W-1:0] FC_NOP  = 4'd0;
  localparam logic [OP_W-1:0] FC_TRAP = 4'd1;
  localparam logic [OP_W-1:0] FC_JMP  = 4'd2;
  localparam logic [OP_W-1:0] FC_JZ   = 4'd3;
  localparam logic [OP_W-1:0] FC_JS   = 4'd4;
  localparam logic [OP_W-1:0] FC_JZS  = 4'd5;
  localparam logic [OP_W-1:0] FC_LSR  = 4'd6;
  localparam logic [OP_W-1:0] FC_XSR  = 4'd7;
  localparam logic [OP_W-1:0] FC_STEP = 4'd8;

  localparam int unsigned ST_ZERO  = 0;
  localparam int unsigned ST_SIGN  = 1;
  localparam int unsigned ST_CARRY = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } fc_state_t;

endpackage

// File: rtl/flow_ctrl_unit_cond_eval.sv
// Jump-taken decision from the opcode and the registered zero/sign flags.
module flow_cond_eval
  import flow_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op_code,
  input  logic            zero,
  input  logic            sign,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (op_code)
      FC_JMP:  taken = 1'b1;
      FC_JZ:   taken = zero;
      FC_JS:   taken = sign;
      FC_JZS:  taken = zero | sign;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flow_ctrl_unit.sv
// Program-flow unit: owns pc and status, resolves jumps/traps/status ops beside the ALU.
module flow_ctrl_unit
  import flow_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   op_code,
  input  logic [ADDR_W-1:0] op_target,
  input  logic [ST_W-1:0]   op_status,
  input  logic              alu_flag_we,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_carry,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              redirect,
  output logic [ST_W-1:0]   status,
  output logic              trapped
);

  fc_state_t         state;
  logic              taken;
  logic [ADDR_W-1:0] pc_inc;

  // Ready is a pure decode of the state register, forced low while reset is held.
  assign op_ready = (state == RUN) && !rst;
  assign pc_inc   = pc + ADDR_W'(1);

  flow_cond_eval u_cond (
    .op_code (op_code),
    .zero    (status[ST_ZERO]),
    .sign    (status[ST_SIGN]),
    .taken   (taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      status   <= '0;
      redirect <= 1'b0;
      trapped  <= 1'b0;
    end else begin
      redirect <= 1'b0;
      // ALU capture comes first so a same-cycle LSR/XSR overrides it.
      if (alu_flag_we) status <= {alu_carry, alu_sign, alu_zero};

      case (state)
        RUN: begin
          if (op_valid) begin
            case (op_code)
              FC_TRAP: begin
                state   <= TRAP;
                trapped <= 1'b1;
              end
              FC_JMP, FC_JZ, FC_JS, FC_JZS: begin
                if (taken) begin
                  pc       <= op_target;
                  redirect <= 1'b1;
                  state    <= FLUSH;
                end else begin
                  pc <= pc_inc;
                end
              end
              FC_LSR: begin
                status <= op_status;
                pc     <= pc_inc;
              end
              FC_XSR: begin
                status <= status ^ op_status;
                pc     <= pc_inc;
              end
              default: pc <= pc_inc;
            endcase
          end
        end
        FLUSH: state <= RUN;
        TRAP: begin
          if (resume) begin
            state   <= RUN;
            trapped <= 1'b0;
            pc      <= pc_inc;
          end
        end
        default: begin
          state   <= RUN;
          trapped <= 1'b0;
        end
      endcase
    end
  end

endmodule
